wb_bram_burst: RTL and testbench

//   Wishbone B4 slave wrapping a byte-enabled synchronous BRAM. Successor to the single-beat
//   RAM slave. Adds byte lanes (wb_sel_i), registered-feedback incrementing bursts
//   (CTI/BTE, linear and wrap-4/8/16), non-power-of-2 depth and an error response for
//   out-of-range addresses. Sits on the system Wishbone bus as data/scratch memory.

---
 rtl/wb_pkg.sv | 33 +++
 rtl/bram_be.sv | 31 +++
 rtl/wb_bram_burst.sv | 160 ++++++++++++++++
 tb/tb_wb_bram_burst.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone constants and FSM encoding for the burst-capable BRAM slave.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_BURST,
    ST_ERR
  } state_e;

  // Low address bits that rotate inside a wrap burst; zero means linear.
  function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
    logic [3:0] m;
    m = 4'h0;
    case (bte)
      BTE_WRAP4:  m = 4'h3;
      BTE_WRAP8:  m = 4'h7;
      BTE_WRAP16: m = 4'hf;
      default:    m = 4'h0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bram_be.sv
// Single-port synchronous RAM with per-byte write enables and a read-first registered output.
module bram_be #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 10,
  localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [SEL_WIDTH-1:0]  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  // One byte-wide array per lane keeps each lane's enable local to its own storage.
  for (genvar i = 0; i < SEL_WIDTH; i++) begin : g_lane
    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (en) begin
        rd_q <= mem[addr];
        if (we[i]) mem[addr] <= din[8*i +: 8];
      end
    end

    assign dout[8*i +: 8] = rd_q;
  end

endmodule

// File: rtl/wb_bram_burst.sv
// Wishbone B4 slave over a byte-enabled BRAM: classic cycles, registered-feedback
// linear/wrap bursts, and err termination for addresses beyond DEPTH.
module wb_bram_burst
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
  input  logic                      wb_we_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_cyc_i,
  input  logic [2:0]                wb_cti_i,
  input  logic [1:0]                wb_bte_i,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  output logic                      wb_ack_o,
  output logic                      wb_err_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;

  logic                    req;
  logic                    adr_ok, next_ok;
  logic [ADDR_WIDTH-1:0]   addr_inc, addr_mask, next_addr;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic                    ram_en;
  logic [SEL_WIDTH-1:0]    ram_we;

  assign req      = wb_cyc_i & wb_stb_i;
  assign wb_ack_o = ack_q & req;
  assign wb_err_o = err_q & req;

  // Wrap bursts keep the upper bits and rotate only the masked low bits.
  assign addr_inc  = cur_addr_q + ADDR_WIDTH'(1);
  assign addr_mask = {{(ADDR_WIDTH-4){1'b0}}, wrap_mask(wb_bte_i)};
  assign next_addr = (wb_bte_i == BTE_LINEAR) ? addr_inc
                   : ((cur_addr_q & ~addr_mask) | (addr_inc & addr_mask));

  assign adr_ok  = ({1'b0, wb_adr_i}  < DEPTH_L);
  assign next_ok = ({1'b0, next_addr} < DEPTH_L);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    ack_d      = ack_q;
    err_d      = err_q;
    ram_en     = 1'b0;
    ram_we     = '0;
    ram_addr   = cur_addr_q;

    if (!wb_cyc_i) begin
      state_d = ST_IDLE;
      ack_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wb_stb_i) begin
            cur_addr_d = wb_adr_i;
            ram_addr   = wb_adr_i;
            if (!adr_ok) begin
              err_d   = 1'b1;
              state_d = ST_ERR;
            end else begin
              ram_en  = 1'b1;
              ack_d   = 1'b1;
              state_d = (wb_cti_i == CTI_INCR) ? ST_BURST : ST_ACK;
            end
          end
        end

        ST_ACK: begin
          if (wb_stb_i) begin
            ram_en  = wb_we_i;
            ram_we  = wb_we_i ? wb_sel_i : '0;
            ack_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end

        ST_BURST: begin
          if (wb_stb_i) begin
            if (wb_we_i) begin
              ram_en = 1'b1;
              ram_we = wb_sel_i;
            end
            if (wb_cti_i != CTI_INCR) begin
              ack_d   = 1'b0;
              state_d = ST_IDLE;
            end else begin
              cur_addr_d = next_addr;
              if (!next_ok) begin
                ack_d   = 1'b0;
                err_d   = 1'b1;
                state_d = ST_ERR;
              end else if (!wb_we_i) begin
                // Prefetch the next word so the following beat has no wait state.
                ram_en   = 1'b1;
                ram_addr = next_addr;
              end
            end
          end
        end

        ST_ERR: begin
          if (wb_stb_i) begin
            err_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  bram_be #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (RAM_AW)
  ) u_ram (
    .clk  (wb_clk_i),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr[RAM_AW-1:0]),
    .din  (wb_dat_i),
    .dout (wb_dat_o)
  );

endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed plus randomized Wishbone traffic against a word-array reference model.
module tb_wb_bram_burst;
  import wb_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_i;
  logic [3:0]    wb_sel;
  logic          wb_we, wb_stb, wb_cyc;
  logic [2:0]    wb_cti;
  logic [1:0]    wb_bte;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack, wb_err;

  int ncmp  = 0;
  int nfail = 0;
  logic [31:0] mdl [1024];

  always #5 clk = ~clk;

  wb_bram_burst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_i (wb_adr),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel),
    .wb_we_i  (wb_we),
    .wb_stb_i (wb_stb),
    .wb_cyc_i (wb_cyc),
    .wb_cti_i (wb_cti),
    .wb_bte_i (wb_bte),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack),
    .wb_err_o (wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic int nxt(input int a, input logic [1:0] b);
    int n;
    if (b == 2'b00) return (a + 1) % 1024;
    n = 2 << b;
    return a - (a % n) + ((a % n) + 1) % n;
  endfunction

  task automatic idle_bus();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0;
    wb_dat_i = '0; wb_sel = '0; wb_cti = CTI_CLASSIC; wb_bte = BTE_LINEAR;
  endtask

  // Called and returns just after a rising edge.
  task automatic classic(input bit we, input int a, input logic [31:0] d, input logic [3:0] s);
    int lat;
    bit got, got_ack, got_err, exp_err;
    logic [31:0] rd;
    exp_err = (a >= DEPTH);
    got = 0; got_ack = 0; got_err = 0; rd = '0; lat = 0;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = AW'(a); wb_dat_i = d; wb_sel = s;
    wb_cti = CTI_CLASSIC; wb_bte = BTE_LINEAR;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (wb_ack || wb_err) begin
        got = 1; got_ack = wb_ack; got_err = wb_err; rd = wb_dat_o;
      end
    end
    chk("classic_latency", 32'(lat), 32'd2);
    chk("classic_ack", 32'(got_ack), 32'(!exp_err));
    chk("classic_err", 32'(got_err), 32'(exp_err));
    if (!exp_err && !we) chk("classic_rdata", rd, mdl[a]);
    if (!exp_err && we) mdl[a] = merge(mdl[a], d, s);
    @(negedge clk);
    chk("classic_resp_one_cycle", {30'd0, wb_ack, wb_err}, 32'd0);
    @(posedge clk); #1; idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic drive_beat(input bit we, input int a, input bit last, input bit rsel);
    wb_adr = AW'(a);
    wb_dat_i = $urandom;
    wb_sel = (we && rsel) ? 4'($urandom) : 4'hf;
    wb_cti = last ? CTI_EOB : CTI_INCR;
  endtask

  task automatic burst(input bit we, input int a0, input logic [1:0] b, input int n,
                       input int stall_after, input int stall_len, input bit rsel);
    int a, beat;
    bit done;
    a = a0; beat = 0; done = 0;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_bte = b;
    drive_beat(we, a, n == 1, rsel);
    @(negedge clk);
    chk("burst_first_wait", {30'd0, wb_ack, wb_err}, 32'd0);
    for (int c = 0; c < 2*n + stall_len + 8 && !done; c++) begin
      @(negedge clk);
      if (a >= DEPTH) begin
        chk("burst_err", {30'd0, wb_ack, wb_err}, 32'd1);
        done = 1;
      end else begin
        chk("burst_ack", {30'd0, wb_ack, wb_err}, 32'd2);
        if (!we) chk("burst_rdata", wb_dat_o, mdl[a]);
        else mdl[a] = merge(mdl[a], wb_dat_i, wb_sel);
        beat++;
        if (beat == n) done = 1;
        else begin
          a = nxt(a, b);
          if (beat == stall_after && stall_len > 0 && a < DEPTH) begin
            @(posedge clk); #1; wb_stb = 0;
            repeat (stall_len) begin
              @(negedge clk);
              chk("stall_ack_low", {30'd0, wb_ack, wb_err}, 32'd0);
              if (!we) chk("stall_data_hold", wb_dat_o, mdl[a]);
            end
            @(posedge clk); #1; wb_stb = 1;
          end else begin
            @(posedge clk); #1;
          end
          drive_beat(we, a, beat == n-1, rsel);
        end
      end
    end
    if (!done) chk("burst_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("burst_end_low", {30'd0, wb_ack, wb_err}, 32'd0);
    @(posedge clk); #1; idle_bus();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mdl[i] = '0;
    idle_bus();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ack", 32'(wb_ack), 32'd0);
    chk("reset_err", 32'(wb_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known contents for every region the traffic touches.
    burst(1, 0,   BTE_LINEAR, 64, 0, 0, 0);
    burst(1, 992, BTE_LINEAR, 8,  0, 0, 0);

    classic(1, 'h010, 32'hDEADBEEF, 4'hf);
    classic(0, 'h010, 32'h0, 4'hf);
    chk("dir_deadbeef_model", mdl['h010], 32'hDEADBEEF);
    classic(1, 'h010, 32'h000000AA, 4'h1);
    classic(0, 'h010, 32'h0, 4'hf);
    chk("dir_lane_merge_model", mdl['h010], 32'hDEADBEAA);

    burst(0, 'h020, BTE_LINEAR, 4, 0, 0, 0);
    burst(0, 'h026, BTE_WRAP4,  4, 2, 2, 0);
    burst(0, 'h02b, BTE_WRAP8,  8, 3, 1, 0);
    burst(0, 'h015, BTE_WRAP16, 6, 0, 0, 0);

    classic(1, 1000, 32'h12345678, 4'hf);
    classic(0, 1000, 32'h0, 4'hf);
    classic(0, 999,  32'h0, 4'hf);
    burst(0, 998, BTE_LINEAR, 4, 0, 0, 0);
    burst(1, 998, BTE_LINEAR, 4, 0, 0, 1);
    classic(0, 998, 32'h0, 4'hf);
    classic(0, 999, 32'h0, 4'hf);

    // Reset lands while beat 2 of a write burst is being acked.
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_bte = BTE_LINEAR;
    drive_beat(1, 'h030, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_beat1_ack", 32'(wb_ack), 32'd1);
    mdl['h030] = merge(mdl['h030], wb_dat_i, wb_sel);
    @(posedge clk); #1;
    drive_beat(1, 'h031, 0, 0);
    @(negedge clk);
    chk("rst_beat2_ack", 32'(wb_ack), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_ack", 32'(wb_ack), 32'd0);
    chk("rst_async_err", 32'(wb_err), 32'd0);
    idle_bus();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    classic(0, 'h030, 32'h0, 4'hf);
    classic(0, 'h031, 32'h0, 4'hf);

    for (int i = 0; i < 60; i++) begin
      int op, a, n, r;
      logic [1:0] b;
      op = $urandom_range(0, 3);
      r  = $urandom_range(0, 9);
      if (op < 2) begin
        if (r < 6)      a = $urandom_range(0, 63);
        else if (r < 9) a = 992 + $urandom_range(0, 7);
        else            a = $urandom_range(1000, 1023);
        classic(op == 0, a, $urandom, 4'($urandom_range(1, 15)));
      end else begin
        b = 2'($urandom_range(0, 3));
        n = $urandom_range(1, 8);
        if (r < 6) a = (b == BTE_LINEAR) ? $urandom_range(0, 64 - n) : $urandom_range(0, 63);
        else       a = 992 + $urandom_range(0, 7);
        burst(op == 2, a, b, n, $urandom_range(1, n), $urandom_range(0, 3), 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
